usb_fs_ep_rr_arb: RTL
=====================

USB_FS_EP_RR_ARB -- requirements
Module: usb_fs_ep_rr_arb

Interface
REQ-001 Parameter NUM_EPS, default 4, number of endpoint channels arbitrated (1..16).
REQ-002 Parameter DATA_W, default 8, endpoint data width in bits.
REQ-003 Parameter HOLD_MAX, default 64, maximum grant tenure in clk cycles; used only with the hold-limit feature.
REQ-004 Local IDX_W = max(1, clog2(NUM_EPS)).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ep_req  input  NUM_EPS  per-endpoint request, level.
REQ-008 ep_grant  output  NUM_EPS  one-hot registered grant; all-zero when idle.
REQ-009 ep_data  input  NUM_EPS*DATA_W  endpoint data; endpoint i occupies bits [i*DATA_W +: DATA_W].
REQ-010 pe_busy  input  1  protocol engine mid-transaction; freezes grant.
REQ-011 arb_valid  output  1  high when any grant is held.
REQ-012 arb_idx  output  IDX_W  index of granted endpoint; 0 when idle.
REQ-013 arb_data  output  DATA_W  granted endpoint's data slice; 0 when arb_valid=0.
REQ-014 hold_expired  output  1  one-cycle pulse on forced release; port always present.

Function
REQ-015 Two states, IDLE and GRANTED, held in a state register.
REQ-016 Round-robin pointer ptr (IDX_W bits) marks the highest-priority index; search order is ptr, ptr+1, ..., wrapping NUM_EPS-1 -> 0.
REQ-017 IDLE, any ep_req set: the first set request in search order is granted; ep_grant, arb_idx, and arb_valid update at the next edge; state -> GRANTED.
REQ-018 IDLE, ep_req all zero: outputs stay idle.
REQ-019 GRANTED: grant holds while ep_req[arb_idx]=1 or pe_busy=1.
REQ-020 GRANTED, ep_req[arb_idx]=0 and pe_busy=0: grant clears at the next edge; ptr <= arb_idx+1 (mod NUM_EPS); state -> IDLE.
REQ-021 Every grant change passes through at least one IDLE cycle; back-to-back handoff is not permitted.
REQ-022 Grant never changes in any cycle where pe_busy=1, regardless of requests or hold limit.
REQ-023 arb_data and arb_valid are combinational from registered arb_idx/state and ep_data; zero added latency.
REQ-024 Changes to non-granted ep_req bits while GRANTED have no effect.
REQ-025 NUM_EPS=1: arb_idx is constant 0; ptr is unused; behaviour is otherwise identical.
REQ-026 ep_grant is always one-hot or zero; a multi-bit grant is illegal.

Reset
REQ-027 Asserting reset immediately, without a clock edge, sets: ep_grant=0, arb_valid=0, arb_idx=0, ptr=0, state=IDLE, hold counter=0, hold_expired=0.
REQ-028 Reset mid-grant abandons the tenure; after deassertion, arbitration restarts from index 0.

Configuration
REQ-029 Macro USB_FS_ARB_HOLD_LIMIT_EN defined: a tenure counter clears on entry to GRANTED and increments each GRANTED cycle.
REQ-030 With USB_FS_ARB_HOLD_LIMIT_EN, forced release occurs when all three hold: counter = HOLD_MAX-1, pe_busy=0, and another endpoint is requesting. Grant clears at the next edge, hold_expired pulses high for that same cycle, ptr <= arb_idx+1, and state -> IDLE.
REQ-031 With USB_FS_ARB_HOLD_LIMIT_EN, if no other endpoint is requesting at the limit, the counter saturates and the grant persists.
REQ-032 Macro undefined: no counter is built; hold_expired is tied 0; tenure is unlimited.

Verification
REQ-033 Reset, then ep_req=4'b0001 -> next edge: ep_grant=0001, arb_idx=0, arb_data=ep_data[7:0]; drop request -> grant 0 next edge.
REQ-034 ep_req=4'b1111; each grantee drops its request for 1 cycle after grant, then re-raises -> grant order 0,1,2,3,0, one IDLE cycle between grants.
REQ-035 Wrap: after endpoint 3 is granted and released, ep_req=4'b1001 -> grant endpoint 0, not 3.
REQ-036 Endpoint 2 granted, pe_busy=1, ep_req[2] drops for 5 cycles -> grant held all 5 cycles; pe_busy falls -> grant clears next edge.
REQ-037 With USB_FS_ARB_HOLD_LIMIT_EN, HOLD_MAX=8, ep_req=4'b0011 steady -> endpoint 0 granted 8 cycles, hold_expired pulses once, then endpoint 1 granted after one IDLE cycle.
REQ-038 Async reset asserted mid-grant between clock edges -> ep_grant=0 and arb_valid=0 before the next edge.

Source files
------------

// File: rtl/usb_fs_ep_rr_arb_if.sv
// Endpoint-side bundle for the USB FS endpoint round-robin arbiter.
// master = arbiter, slave = endpoint/protocol-engine side.
interface usb_fs_ep_rr_arb_if #(
  parameter int NUM_EPS = 4,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1
);
  logic [NUM_EPS-1:0]        ep_req;
  logic [NUM_EPS-1:0]        ep_grant;
  logic [NUM_EPS*DATA_W-1:0] ep_data;
  logic                      pe_busy;
  logic                      arb_valid;
  logic [IDX_W-1:0]          arb_idx;
  logic [DATA_W-1:0]         arb_data;
  logic                      hold_expired;

  modport master (
    input  ep_req, ep_data, pe_busy,
    output ep_grant, arb_valid, arb_idx,
    output arb_data, hold_expired
  );

  modport slave (
    output ep_req, ep_data, pe_busy,
    input  ep_grant, arb_valid, arb_idx,
    input  arb_data, hold_expired
  );
endinterface

// File: rtl/usb_fs_ep_rr_arb.sv
// Round-robin endpoint arbiter with pe_busy freeze.
// Optional tenure limit: define USB_FS_ARB_HOLD_LIMIT_EN.
module usb_fs_ep_rr_arb #(
  parameter int NUM_EPS  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  usb_fs_ep_rr_arb_if.master bus
);
  localparam int IDX_W = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_EPS-1:0] r_grant;

  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  logic               w_cur;
  logic               w_other;
  logic [IDX_W-1:0]   w_nxt_ptr;

  // Walk from lowest to highest priority so the first hit in order wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_EPS - 1; k >= 0; k--) begin
      if (bus.ep_req[(int'(r_ptr) + k) % NUM_EPS]) begin
        w_any = 1'b1;
        w_sel = IDX_W'((int'(r_ptr) + k) % NUM_EPS);
      end
    end
  end

  assign w_cur     = |(bus.ep_req & r_grant);
  assign w_other   = |(bus.ep_req & ~r_grant);
  assign w_nxt_ptr = IDX_W'((int'(r_idx) + 1) % NUM_EPS);

`ifdef USB_FS_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hexp;
  logic             w_limit;

  assign w_limit = (r_cnt == CNT_LAST) && w_other;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
`ifdef USB_FS_ARB_HOLD_LIMIT_EN
      r_cnt   <= '0;
      r_hexp  <= 1'b0;
`endif
    end else begin
`ifdef USB_FS_ARB_HOLD_LIMIT_EN
      r_hexp <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_idx   <= w_sel;
            r_grant <= NUM_EPS'(1) << w_sel;
`ifdef USB_FS_ARB_HOLD_LIMIT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!bus.pe_busy && !w_cur) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= w_nxt_ptr;
`ifdef USB_FS_ARB_HOLD_LIMIT_EN
          end else if (!bus.pe_busy && w_limit) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= w_nxt_ptr;
            r_hexp  <= 1'b1;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ep_grant  = r_grant;
  assign bus.arb_idx   = r_idx;
  assign bus.arb_valid = (r_state == S_GRANT);
  assign bus.arb_data  = (r_state == S_GRANT)
                       ? bus.ep_data[int'(r_idx)*DATA_W +: DATA_W]
                       : '0;
`ifdef USB_FS_ARB_HOLD_LIMIT_EN
  assign bus.hold_expired = r_hexp;
`else
  assign bus.hold_expired = 1'b0;
`endif
endmodule
